// File: rtl/mips_dbg_pkg.sv
// rtl/mips_dbg_pkg.sv - shared types and constants for the MIPS run monitor
// Contents: run-control state enum, run-end cause encodings, BREAK opcode/funct
// constants and a BREAK decode helper.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;
    localparam logic [1:0] CAUSE_BREAK   = 2'd2;
    localparam logic [1:0] CAUSE_STALL   = 2'd3;

    // BREAK is an R-type (SPECIAL) instruction with funct 0x0D; the code
    // field in bits 25:6 is ignored.
    localparam logic [5:0] BREAK_OPCODE = 6'h00;
    localparam logic [5:0] BREAK_FUNCT  = 6'h0D;

    function automatic logic is_break_instr(input logic [31:0] ins);
        return (ins[31:26] == BREAK_OPCODE) && (ins[5:0] == BREAK_FUNCT);
    endfunction

endpackage

// File: rtl/mips_trace_ram.sv
// rtl/mips_trace_ram.sv - trace storage, one write port and one registered read port
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address, sampled every cycle
//   rdata_o  read data, one cycle after raddr_i; returns the pre-write
//            contents when reading the slot written on the same edge
module mips_trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is not reset; the top masks unwritten entries on read.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_run_monitor.sv
// rtl/mips_run_monitor.sv - run control, cycle limit and PC/IR trace monitor for the MIPS core
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-low reset
//   start      one-cycle pulse, starts a run from IDLE or DONE
//   pc, instr  core program counter and the instruction at pc
//   rd_idx     trace read index, 0 = oldest valid entry
//   running    high in RUN
//   done       high in DONE
//   cause      run-end cause (none/timeout/break/stall)
//   cycle_cnt  cycles spent in RUN
//   trace_cnt  valid trace entries, saturating at TRACE_DEPTH
//   trace_ovf  sticky, set once an entry has been overwritten
//   rd_pc      registered PC of entry rd_idx (0 when rd_idx >= trace_cnt)
//   rd_instr   registered instruction of entry rd_idx (0 when rd_idx >= trace_cnt)
module mips_run_monitor
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MAX_CYCLES  = 2048,
    parameter int TRACE_DEPTH = 16,
    parameter int STALL_LIMIT = 8,
    parameter int CNT_W       = 32
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           start,
    input  logic [DATA_W-1:0]              pc,
    input  logic [DATA_W-1:0]              instr,
    input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
    output logic                           running,
    output logic                           done,
    output logic [1:0]                     cause,
    output logic [CNT_W-1:0]               cycle_cnt,
    output logic [$clog2(TRACE_DEPTH):0]   trace_cnt,
    output logic                           trace_ovf,
    output logic [DATA_W-1:0]              rd_pc,
    output logic [DATA_W-1:0]              rd_instr
);

    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int SW = $clog2(STALL_LIMIT) + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [AW:0]       tcnt_q, tcnt_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        cause_q, cause_d;
    logic [SW-1:0]     stall_q, stall_d;
    logic [DATA_W-1:0] last_pc_q, last_pc_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              first_q, first_d;
    logic              rd_valid_q;

    logic                wr_en;
    logic                same_pc;
    logic                fire_break;
    logic                fire_stall;
    logic                fire_timeout;
    logic [AW-1:0]       rd_addr;
    logic [2*DATA_W-1:0] rd_data;

    assign same_pc = (pc == last_pc_q);

    always_comb begin
        state_d      = state_q;
        cycle_d      = cycle_q;
        tcnt_d       = tcnt_q;
        ovf_d        = ovf_q;
        cause_d      = cause_q;
        stall_d      = stall_q;
        last_pc_d    = last_pc_q;
        wr_ptr_d     = wr_ptr_q;
        first_d      = first_q;
        wr_en        = 1'b0;
        fire_break   = 1'b0;
        fire_stall   = 1'b0;
        fire_timeout = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    cycle_d   = '0;
                    tcnt_d    = '0;
                    ovf_d     = 1'b0;
                    cause_d   = CAUSE_NONE;
                    stall_d   = '0;
                    last_pc_d = pc;
                    first_d   = 1'b1;
                end
            end
            RUN: begin
                cycle_d = cycle_q + CNT_W'(1);
                first_d = 1'b0;

                if (same_pc) begin
                    stall_d = stall_q + 1'b1;
                end else begin
                    stall_d   = '0;
                    last_pc_d = pc;
                end

                // The first RUN cycle is always recorded, even when pc did
                // not move since the start edge.
                wr_en = first_q || !same_pc;
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (tcnt_q == (AW+1)'(TRACE_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end

                fire_break   = is_break_instr(instr[31:0]);
                fire_stall   = same_pc && (stall_q == SW'(STALL_LIMIT - 2));
                fire_timeout = (cycle_q + CNT_W'(1)) == CNT_W'(MAX_CYCLES);

                if (fire_break) begin
                    cause_d = CAUSE_BREAK;
                    state_d = DONE;
                end else if (fire_stall) begin
                    cause_d = CAUSE_STALL;
                    state_d = DONE;
                end else if (fire_timeout) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            cycle_q    <= '0;
            tcnt_q     <= '0;
            ovf_q      <= 1'b0;
            cause_q    <= CAUSE_NONE;
            stall_q    <= '0;
            last_pc_q  <= '0;
            wr_ptr_q   <= '0;
            first_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            tcnt_q     <= tcnt_d;
            ovf_q      <= ovf_d;
            cause_q    <= cause_d;
            stall_q    <= stall_d;
            last_pc_q  <= last_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            first_q    <= first_d;
            rd_valid_q <= ({1'b0, rd_idx} < tcnt_q);
        end
    end

    // Oldest valid entry sits trace_cnt slots behind the write pointer; the
    // truncation to AW bits performs the modulo-TRACE_DEPTH wrap.
    assign rd_addr = wr_ptr_q - tcnt_q[AW-1:0] + rd_idx;

    mips_trace_ram #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (2*DATA_W)
    ) u_trace_ram (
        .clk_i   (CLK),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({pc, instr}),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign running   = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign cause     = cause_q;
    assign cycle_cnt = cycle_q;
    assign trace_cnt = tcnt_q;
    assign trace_ovf = ovf_q;
    assign rd_pc     = rd_valid_q ? rd_data[2*DATA_W-1:DATA_W] : '0;
    assign rd_instr  = rd_valid_q ? rd_data[DATA_W-1:0]        : '0;

endmodule

// File: tb/tb_mips_run_monitor.sv
// tb/tb_mips_run_monitor.sv - scoreboard testbench for mips_run_monitor
module tb_mips_run_monitor;

    localparam int DATA_W      = 32;
    localparam int MAX_CYCLES  = 2048;
    localparam int TRACE_DEPTH = 16;
    localparam int STALL_LIMIT = 8;
    localparam int CNT_W       = 32;
    localparam int AW          = 4;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       pc = '0;
    logic [31:0]       instr = '0;
    logic [AW-1:0]     rd_idx = '0;
    logic              running;
    logic              done;
    logic [1:0]        cause;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [AW:0]       trace_cnt;
    logic              trace_ovf;
    logic [31:0]       rd_pc;
    logic [31:0]       rd_instr;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] cyc;
        logic [4:0]  tcnt;
        logic        ovf;
    } run_exp_t;

    run_exp_t    exp_run_q[$];
    logic [63:0] exp_rd_q[$];
    logic [63:0] mtrace[$];
    bit          rd_req = 1'b0;

    mips_run_monitor #(
        .DATA_W      (DATA_W),
        .MAX_CYCLES  (MAX_CYCLES),
        .TRACE_DEPTH (TRACE_DEPTH),
        .STALL_LIMIT (STALL_LIMIT),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .pc        (pc),
        .instr     (instr),
        .rd_idx    (rd_idx),
        .running   (running),
        .done      (done),
        .cause     (cause),
        .cycle_cnt (cycle_cnt),
        .trace_cnt (trace_cnt),
        .trace_ovf (trace_ovf),
        .rd_pc     (rd_pc),
        .rd_instr  (rd_instr)
    );

    always #5 CLK = ~CLK;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic bit is_brk(input logic [31:0] i);
        return (i[31:26] == 6'd0) && (i[5:0] == 6'h0D);
    endfunction

    function automatic logic [31:0] nonbrk(input logic [31:0] i);
        logic [31:0] r;
        r = i;
        if (is_brk(r)) r[26] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] rand_pc();
        return BASE | ($urandom() & 32'h0000_FFFC);
    endfunction

    function automatic int mcount();
        return (mtrace.size() > TRACE_DEPTH) ? TRACE_DEPTH : mtrace.size();
    endfunction

    // Index 0 is the oldest of the last TRACE_DEPTH recorded entries.
    function automatic logic [63:0] model_read(input int idx);
        int n;
        n = mcount();
        if (idx < n) return mtrace[mtrace.size() - n + idx];
        return 64'd0;
    endfunction

    task automatic read_phase(input int nreads);
        for (int i = 0; i < nreads; i++) begin
            logic [AW-1:0] idx;
            idx = (i < TRACE_DEPTH) ? AW'(i) : AW'($urandom_range(0, TRACE_DEPTH-1));
            rd_idx = idx;
            rd_req = 1'b1;
            exp_rd_q.push_back(model_read(int'(idx)));
            @(posedge CLK); #1;
        end
        rd_req = 1'b0;
    endtask

    // mode: 0 random, 1 stall-biased, 2 timeout, 3 timeout with break on the
    // last cycle, 4 break on cycle 5, 5 stall after 3 pcs, 6 reset at cycle 100
    task automatic do_run(input int mode);
        logic [31:0] p, anchor, ins;
        int cyc, r;
        bit first, ended, aborted, brk, stl, to;
        run_exp_t e;

        p = (mode >= 2) ? BASE : rand_pc();
        @(posedge CLK); #1;
        start = 1'b1;
        pc    = p;
        instr = nonbrk($urandom());
        mtrace.delete();
        anchor = p; r = 0; cyc = 0; first = 1'b1; ended = 1'b0; aborted = 1'b0;
        @(posedge CLK); #1;
        start = 1'b0;
        check("start_running", running, 1);
        check("start_done", done, 0);
        check("start_cycle_cnt", cycle_cnt, 0);
        check("start_trace_cnt", trace_cnt, 0);
        check("start_ovf", trace_ovf, 0);
        check("start_cause", cause, 0);

        while (!ended && !aborted) begin
            cyc++;
            ins = nonbrk($urandom());
            case (mode)
                0: begin
                    if ($urandom_range(0, 99) >= 30) p = rand_pc();
                    if ($urandom_range(0, 99) < 3) ins = ($urandom() & 32'h03FF_FFC0) | 32'h0000_000D;
                    if ($urandom_range(0, 99) < 5) start = 1'b1;
                end
                1: if ($urandom_range(0, 99) >= 85) p = rand_pc();
                2, 4, 6: begin
                    p = BASE + 32'(4 * (cyc - 1));
                    if (mode == 4 && cyc == 5) ins = 32'h0000_000D;
                end
                3: begin
                    p = BASE + 32'(4 * (cyc - 1));
                    if (cyc == MAX_CYCLES) ins = 32'h0000_000D;
                end
                default: p = (cyc <= 3) ? BASE + 32'(4 * (cyc - 1)) : 32'h0040_0020;
            endcase
            pc    = p;
            instr = ins;

            if (first || p != anchor) mtrace.push_back({p, ins});
            if (p == anchor) r++;
            else begin
                r = 0;
                anchor = p;
            end
            first = 1'b0;
            brk = is_brk(ins);
            stl = (r == STALL_LIMIT - 1);
            to  = (cyc == MAX_CYCLES);
            if (brk || stl || to) begin
                e.cause = brk ? 2'd2 : (stl ? 2'd3 : 2'd1);
                e.cyc   = 32'(cyc);
                e.tcnt  = 5'(mcount());
                e.ovf   = (mtrace.size() > TRACE_DEPTH);
                exp_run_q.push_back(e);
                ended = 1'b1;
            end

            @(posedge CLK); #1;
            start = 1'b0;
            if (cyc == 1 && !ended) check("first_cycle_trace_cnt", trace_cnt, 1);
            if (mode == 6 && cyc == 100) begin
                RST = 1'b0;
                #1;
                check("rst_running", running, 0);
                check("rst_done", done, 0);
                check("rst_cycle_cnt", cycle_cnt, 0);
                check("rst_trace_cnt", trace_cnt, 0);
                check("rst_cause", cause, 0);
                check("rst_ovf", trace_ovf, 0);
                RST = 1'b1;
                mtrace.delete();
                aborted = 1'b1;
            end
        end

        if (ended) begin
            check("end_done", done, 1);
            check("end_running", running, 0);
        end
        read_phase(20);
    endtask

    // Monitor: compares registered reads one edge after the request, and the
    // run summary whenever done rises.
    initial begin
        bit       req_now;
        logic     done_prev;
        run_exp_t e;
        logic [63:0] er;
        done_prev = 1'b0;
        forever begin
            @(posedge CLK);
            req_now = rd_req;
            @(negedge CLK);
            if (req_now) begin
                if (exp_rd_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rd_unexpected: got read with no expected entry");
                end else begin
                    er = exp_rd_q.pop_front();
                    check("rd_pc", rd_pc, er[63:32]);
                    check("rd_instr", rd_instr, er[31:0]);
                end
            end
            if (done && !done_prev) begin
                if (exp_run_q.size() == 0) begin
                    n_total++;
                    $display("FAIL run_unexpected: done rose at cycle_cnt %0d with no expected run end", cycle_cnt);
                end else begin
                    e = exp_run_q.pop_front();
                    check("cause", cause, e.cause);
                    check("cycle_cnt", cycle_cnt, e.cyc);
                    check("trace_cnt", trace_cnt, e.tcnt);
                    check("trace_ovf", trace_ovf, e.ovf);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_running", running, 0);
        check("reset_done", done, 0);
        check("reset_cause", cause, 0);
        check("reset_cycle_cnt", cycle_cnt, 0);
        check("reset_trace_cnt", trace_cnt, 0);
        check("reset_ovf", trace_ovf, 0);
        check("reset_rd_pc", rd_pc, 0);
        check("reset_rd_instr", rd_instr, 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        do_run(4);
        do_run(5);
        do_run(2);
        do_run(3);
        do_run(6);
        do_run(4);
        for (int i = 0; i < 16; i++) do_run((i % 3 == 2) ? 1 : 0);

        repeat (5) @(posedge CLK);
        #1;
        check("run_queue_empty", exp_run_q.size(), 0);
        check("rd_queue_empty", exp_rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
